// File: rtl/iofocus_sequencer.sv
// Command sequencer in front of the I/O focus list: queues OS insert/remove requests,
// arbitrates hot-key next/prev, and tracks the focused task. Optional: IOFOCUS_AUTOADV_EN.
module iofocus_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_remove_i,
  input  logic [5:0] req_tid_i,
  input  logic       kbd_next_i,
  input  logic       kbd_prev_i,
  output logic [6:0] fl_cmd_o,
  output logic [5:0] fl_tid_o,
  input  logic [6:0] fl_tid_i,
  input  logic       fl_done_i,
  output logic [6:0] focus_tid_o,
  output logic       focus_chg_o,
  output logic       busy_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 7;

  localparam logic [6:0] CMD_NOP    = 7'd0;
  localparam logic [6:0] CMD_INSERT = 7'd16;
  localparam logic [6:0] CMD_REMOVE = 7'd17;
  localparam logic [6:0] CMD_GETNXT = 7'd18;
  localparam logic [6:0] CMD_GETPRV = 7'd19;
  localparam logic [6:0] FOCUS_NONE = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESULT,
    S_AUTO
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic            nxt_q, nxt_d, prv_q, prv_d;
  logic [6:0]      fl_cmd_q, fl_cmd_d;
  logic [5:0]      fl_tid_q, fl_tid_d;
  logic [6:0]      op_q, op_d;
  logic            src_fifo_q, src_fifo_d;
  logic [6:0]      focus_q, focus_d;
  logic            chg_q, chg_d;

  logic            empty, full, push, pop, clr_nxt, clr_prv, hot_ok, head_rm;
  logic [EW-1:0]   head;

  // FIFO status: an extra pointer bit distinguishes full from empty
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push    = req_valid_i && !full;
  assign head    = mem_q[rptr_q[AW-1:0]];
  assign hot_ok  = (focus_q != FOCUS_NONE);
  assign head_rm = (fl_tid_i == 7'd1) || ({1'b0, fl_tid_q} == focus_q);

  always_comb begin
    state_d    = state_q;
    fl_cmd_d   = fl_cmd_q;
    fl_tid_d   = fl_tid_q;
    op_d       = op_q;
    src_fifo_d = src_fifo_q;
    focus_d    = focus_q;
    pop        = 1'b0;
    clr_nxt    = 1'b0;
    clr_prv    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // With nothing focused there is nothing to step through; drop hot-keys.
        if (!hot_ok) begin
          clr_nxt = 1'b1;
          clr_prv = 1'b1;
        end
        if (hot_ok && nxt_q) begin
          fl_cmd_d   = CMD_GETNXT;
          fl_tid_d   = 6'd0;
          op_d       = CMD_GETNXT;
          src_fifo_d = 1'b0;
          clr_nxt    = 1'b1;
          state_d    = S_ISSUE;
        end else if (hot_ok && prv_q) begin
          fl_cmd_d   = CMD_GETPRV;
          fl_tid_d   = 6'd0;
          op_d       = CMD_GETPRV;
          src_fifo_d = 1'b0;
          clr_prv    = 1'b1;
          state_d    = S_ISSUE;
        end else if (!empty) begin
          fl_cmd_d   = head[6] ? CMD_REMOVE : CMD_INSERT;
          fl_tid_d   = head[5:0];
          op_d       = head[6] ? CMD_REMOVE : CMD_INSERT;
          src_fifo_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fl_cmd_d = CMD_NOP;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (fl_done_i) state_d = S_RESULT;
      end
      S_RESULT: begin
        pop     = src_fifo_q;
        state_d = S_IDLE;
        case (op_q)
          CMD_GETNXT, CMD_GETPRV: focus_d = fl_tid_i;
          CMD_INSERT: begin
            if (focus_q == FOCUS_NONE) focus_d = {1'b0, fl_tid_q};
          end
          CMD_REMOVE: begin
            if (head_rm) begin
`ifdef IOFOCUS_AUTOADV_EN
              state_d = S_AUTO;
`else
              focus_d = FOCUS_NONE;
`endif
            end
          end
          default: ;
        endcase
      end
`ifdef IOFOCUS_AUTOADV_EN
      S_AUTO: begin
        fl_cmd_d   = CMD_GETNXT;
        fl_tid_d   = 6'd0;
        op_d       = CMD_GETNXT;
        src_fifo_d = 1'b0;
        state_d    = S_ISSUE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    chg_d = (focus_d != focus_q);
    nxt_d = kbd_next_i || (nxt_q && !clr_nxt);
    prv_d = kbd_prev_i || (prv_q && !clr_prv);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      nxt_q      <= 1'b0;
      prv_q      <= 1'b0;
      fl_cmd_q   <= CMD_NOP;
      fl_tid_q   <= 6'd0;
      op_q       <= CMD_NOP;
      src_fifo_q <= 1'b0;
      focus_q    <= FOCUS_NONE;
      chg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      nxt_q      <= nxt_d;
      prv_q      <= prv_d;
      fl_cmd_q   <= fl_cmd_d;
      fl_tid_q   <= fl_tid_d;
      op_q       <= op_d;
      src_fifo_q <= src_fifo_d;
      focus_q    <= focus_d;
      chg_q      <= chg_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {req_remove_i, req_tid_i};
  end

  assign req_ready_o = !full;
  assign busy_o      = (state_q != S_IDLE);
  assign fl_cmd_o    = fl_cmd_q;
  assign fl_tid_o    = fl_tid_q;
  assign focus_tid_o = focus_q;
  assign focus_chg_o = chg_q;

endmodule

// File: tb/tb_iofocus_sequencer.sv
// Scoreboard bench for iofocus_sequencer: expected commands/focus changes are queued by
// the stimulus and checked by an independent monitor. Honors IOFOCUS_AUTOADV_EN.
module tb_iofocus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_remove;
  logic [5:0] req_tid;
  logic       kbd_next, kbd_prev;
  logic [6:0] fl_cmd;
  logic [5:0] fl_tid_out;
  logic [6:0] fl_tid_in = 7'd0;
  logic       fl_done;
  logic [6:0] focus_tid;
  logic       focus_chg, busy;

  int errors = 0;
  int checks = 0;

  logic [12:0] exp_cmd_q[$];
  logic [6:0]  exp_res_q[$];
  logic [6:0]  exp_focus_q[$];

  always #5 clk = ~clk;

  iofocus_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_remove_i(req_remove), .req_tid_i(req_tid),
    .kbd_next_i(kbd_next), .kbd_prev_i(kbd_prev),
    .fl_cmd_o(fl_cmd), .fl_tid_o(fl_tid_out),
    .fl_tid_i(fl_tid_in), .fl_done_i(fl_done),
    .focus_tid_o(focus_tid), .focus_chg_o(focus_chg), .busy_o(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_cmd(input logic [6:0] cmd, input logic [5:0] tid, input logic [6:0] res);
    exp_cmd_q.push_back({cmd, tid});
    exp_res_q.push_back(res);
  endtask

  // Focus-list model: returns the scripted result of each command from the cycle after ISSUE.
  always @(negedge clk) begin
    if (rst_n && fl_cmd != 7'd0 && exp_res_q.size() > 0) fl_tid_in = exp_res_q.pop_front();
  end

  // Monitor: every issued command cycle and every focus change is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fl_cmd != 7'd0) begin
        if (exp_cmd_q.size() == 0) chk("unexpected_cmd", int'({fl_cmd, fl_tid_out}), 0);
        else chk("cmd_tid", int'({fl_cmd, fl_tid_out}), int'(exp_cmd_q.pop_front()));
      end
      if (focus_chg) begin
        if (exp_focus_q.size() == 0) chk("unexpected_focus_chg", int'(focus_tid), 0);
        else chk("focus_chg_value", int'(focus_tid), int'(exp_focus_q.pop_front()));
      end
    end
  end

  task automatic push(input logic rm, input logic [5:0] tid);
    @(negedge clk);
    req_valid = 1'b1; req_remove = rm; req_tid = tid;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 400 && !(exp_cmd_q.size() == 0 && !busy)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("wait_idle_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_values();
    chk("rst_fl_cmd", int'(fl_cmd), 0);
    chk("rst_fl_tid", int'(fl_tid_out), 0);
    chk("rst_focus", int'(focus_tid), 127);
    chk("rst_focus_chg", int'(focus_chg), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_remove = 1'b0; req_tid = 6'd0;
    kbd_next = 1'b0; kbd_prev = 1'b0; fl_done = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_values();
    rst_n = 1'b1;

    // Hot-key with nothing focused is dropped.
    @(negedge clk); kbd_prev = 1'b1;
    @(negedge clk); kbd_prev = 1'b0;
    repeat (6) @(negedge clk);
    chk("prev_empty_focus", int'(focus_tid), 127);
    chk("prev_empty_busy", int'(busy), 0);

    // Two inserts; the first takes focus.
    expect_cmd(7'd16, 6'd5, 7'd0);
    expect_cmd(7'd16, 6'd9, 7'd0);
    exp_focus_q.push_back(7'd5);
    push(1'b0, 6'd5);
    push(1'b0, 6'd9);
    wait_idle();
    chk("focus_after_inserts", int'(focus_tid), 5);

    // Next hot-key moves focus to the list's answer.
    expect_cmd(7'd18, 6'd0, 7'd9);
    exp_focus_q.push_back(7'd9);
    @(negedge clk); kbd_next = 1'b1;
    @(negedge clk); kbd_next = 1'b0;
    wait_idle();
    chk("focus_after_next", int'(focus_tid), 9);

    // Stalled list: four requests fill the FIFO, the fifth is refused.
    fl_done = 1'b0;
    for (int i = 0; i < 4; i++) expect_cmd(7'd16, 6'(20 + i), 7'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready", int'(req_ready), (i < 4) ? 1 : 0);
      req_valid = 1'b1; req_remove = 1'b0; req_tid = 6'(20 + i);
    end
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall_busy", int'(busy), 1);
    chk("stall_pending_cmds", exp_cmd_q.size(), 3);
    fl_done = 1'b1;
    wait_idle();
    chk("focus_after_stall", int'(focus_tid), 9);

    // Remove the focused task; the list reports it was the head.
    expect_cmd(7'd17, 6'd9, 7'd1);
`ifdef IOFOCUS_AUTOADV_EN
    expect_cmd(7'd18, 6'd0, 7'd5);
    exp_focus_q.push_back(7'd5);
`else
    exp_focus_q.push_back(7'h7F);
`endif
    push(1'b1, 6'd9);
    wait_idle();
`ifdef IOFOCUS_AUTOADV_EN
    chk("focus_after_remove", int'(focus_tid), 5);
`else
    chk("focus_after_remove", int'(focus_tid), 127);
`endif

    // A fresh insert restores focus only when nothing is focused.
    expect_cmd(7'd16, 6'd40, 7'd0);
`ifndef IOFOCUS_AUTOADV_EN
    exp_focus_q.push_back(7'd40);
`endif
    push(1'b0, 6'd40);
    wait_idle();
`ifdef IOFOCUS_AUTOADV_EN
    chk("focus_after_insert40", int'(focus_tid), 5);
`else
    chk("focus_after_insert40", int'(focus_tid), 40);
`endif

    // Simultaneous next, prev and OS push: GETNXT, GETPRV, then FIFO.
    expect_cmd(7'd18, 6'd0, 7'd9);
    expect_cmd(7'd19, 6'd0, 7'd5);
    expect_cmd(7'd16, 6'd30, 7'd0);
    exp_focus_q.push_back(7'd9);
    exp_focus_q.push_back(7'd5);
    @(negedge clk);
    req_valid = 1'b1; req_remove = 1'b0; req_tid = 6'd30; kbd_next = 1'b1; kbd_prev = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; kbd_next = 1'b0; kbd_prev = 1'b0;
    wait_idle();
    chk("focus_after_priority", int'(focus_tid), 5);

    // Reset mid-command discards the in-flight and queued requests.
    fl_done = 1'b0;
    expect_cmd(7'd16, 6'd50, 7'd0);
    push(1'b0, 6'd50);
    push(1'b0, 6'd51);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    @(negedge clk);
    rst_n = 1'b1; fl_done = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_focus", int'(focus_tid), 127);

    chk("cmd_queue_drained", exp_cmd_q.size(), 0);
    chk("focus_queue_drained", exp_focus_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iofocus_sequencer.md
# iofocus_sequencer

Command sequencer upstream of the I/O focus list. It accepts insert/remove requests from the OS task manager through a 4-entry FIFO and next/prev focus hot-key pulses from the keyboard path. It issues exactly one focus-list command at a time and tracks completion over the list's `done` handshake. It keeps the registered identity of the focused task for the keyboard/video routers.

## Interface
Parameters
- `FIFO_DEPTH`, 4: OS request FIFO entries; must be a power of 2.

Ports
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; one clock, reset is asynchronous and active-low.
- `req_valid_i` in 1: OS request valid.
- `req_ready_o` out 1: FIFO not full; a request is accepted when both `req_valid_i` and `req_ready_o` are high.
- `req_remove_i` in 1: 1 = remove, 0 = insert.
- `req_tid_i` in 6: task id for the request.
- `kbd_next_i` in 1: single-cycle pulse requesting focus to the next task.
- `kbd_prev_i` in 1: single-cycle pulse requesting focus to the previous task.
- `fl_cmd_o` out 7: command to the focus list; 0 = NOP, 16 = INSERT, 17 = REMOVE, 18 = GETNXT, 19 = GETPRV.
- `fl_tid_o` out 6: task id to the focus list.
- `fl_tid_i` in 7: result from the focus list.
- `fl_done_i` in 1: focus-list done; high while the list is idle.
- `focus_tid_o` out 7: focused task; 7'h7F = none.
- `focus_chg_o` out 1: one-cycle pulse when `focus_tid_o` changes.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- FIFO: stores {remove, tid}. Pointers are 3 bits and wrap. Full when the pointers' MSBs differ and the low bits are equal.
  - A push while full is ignored; `req_ready_o` is low in that case.
  - A push and a pop in the same cycle are both legal.
- Hot-key flags: `nxt_pend` and `prv_pend` are set by their pulses.
  - A flag is cleared when its command is issued.
  - A pulse arriving in the same cycle the flag clears re-arms the flag.
- States:
  - IDLE: select a source. Priority is `nxt_pend`, then `prv_pend`, then FIFO not empty. Register `fl_cmd_o`/`fl_tid_o` and go to ISSUE. Hot-key commands drive `fl_tid_o` = 0.
    - If `focus_tid_o`==7'h7F, pending hot-key flags are dropped and no command is issued.
  - ISSUE: hold the command for this single cycle. Next edge: `fl_cmd_o` <= 0 and go to WAIT.
  - WAIT: `fl_tid_o` is held stable. When `fl_done_i` is high, go to RESULT.
  - RESULT: apply the outcome (see Result rules), pop the FIFO entry if the command came from the FIFO, then go to IDLE.
  - AUTO (macro only): issue GETNXT, then re-enter ISSUE → WAIT → RESULT with the hot-key result rule.
- Result rules:
  - GETNXT/GETPRV: `focus_tid_o` <= `fl_tid_i`.
  - INSERT: if `focus_tid_o`==7'h7F, `focus_tid_o` <= inserted tid.
  - REMOVE: if `fl_tid_i`==1, the removed task was the head; see Configuration.
  - `focus_chg_o` pulses only when the value actually changes.
- A REMOVE whose tid equals `focus_tid_o` is treated as head removal.

## Timing
- Reset values: `fl_cmd_o`=0, `fl_tid_o`=0, `focus_tid_o`=7'h7F, `focus_chg_o`=0, `busy_o`=0, `req_ready_o`=1. FIFO is empty, flags are clear, state is IDLE.
- Minimum command latency is IDLE → ISSUE → WAIT → RESULT → IDLE, 4 cycles, when the list completes immediately.
  - A no-op command leaves `fl_done_i` high in the WAIT cycle.
  - A busy list drops `fl_done_i` in the cycle after ISSUE, so `fl_done_i` in WAIT is the true completion.
- `focus_tid_o` updates on the RESULT edge. `focus_chg_o` is high the following cycle.
- An accepted FIFO push is visible to IDLE selection on the next cycle.
- Reset asserted mid-operation: everything returns to its reset value immediately and queued requests are lost. The focus list itself is reset by the same system reset.

## Configuration
- `IOFOCUS_AUTOADV_EN` defined: on REMOVE with `fl_tid_i`==1, the sequencer goes to AUTO and issues GETNXT. `focus_tid_o` takes the new head, or 7'h7F if the list returns 7'h7F.
- Not defined: on head removal, `focus_tid_o` <= 7'h7F and `focus_chg_o` pulses. The next INSERT restores focus.

## Test plan
- After reset, push insert tid 5, then insert tid 9 → `focus_tid_o`=5 with one `focus_chg_o`. The list receives two INSERT commands, each one cycle wide.
- With {5, 9} in the list, pulse `kbd_next_i` → a GETNXT issues; list returns 9 → `focus_tid_o`=9 and `focus_chg_o` pulses.
- With an empty list, pulse `kbd_prev_i` → no command issues and `focus_tid_o` stays 7'h7F.
- Push 5 requests back-to-back while the list is stalled with done low → the fifth sees `req_ready_o`=0. All 4 queued requests issue in order after done rises.
- Remove the focused tid 9 with list result 1 → macro defined: GETNXT issues and `focus_tid_o`=5; macro undefined: `focus_tid_o`=7'h7F.
- Pulse `kbd_next_i` and `kbd_prev_i` in the same cycle as an OS push → order is GETNXT, GETPRV, then the FIFO request.
